mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage consumer of the decoder's MemWrite/MemtoReg/strCtrl (funct3) controls.
- Turns a load/store in the M stage into a valid/ready request to data memory: lane-aligned write data plus byte strobes for stores.
- Waits for the load response, then lane-selects and sign- or zero-extends it for writeback.
- Stalls the pipeline until the access completes.

Parameters:
- ADDR_W, 32, address width; upper bits pass through to dmem_addr.
- DATA_W, 32, data width; only 32 is supported, and other values are an elaboration error.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- MemWriteM  in  1  store in M stage
- MemtoRegM  in  1  load in M stage
- strCtrlM  in  3  funct3 of the M-stage instruction
- ALUResultM  in  ADDR_W  effective byte address
- WriteDataM  in  32  store data (rs2)
- stallM  out  1  hold F/D/E/M stages
- ReadDataW  out  32  formatted load result
- ReadValidW  out  1  ReadDataW valid (one-cycle pulse)
- misalignM  out  1  misaligned-access pulse
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address ([1:0] = 0)
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables (0 for loads)
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data

Behaviour:
- Reset (rst high at a clk edge, synchronous):
  - state goes to IDLE.
  - All outputs are 0, except stallM, which follows the IDLE rule below.
  - An in-flight access is abandoned. A late dmem_rvalid arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - access = MemWriteM | MemtoRegM. If both are set, the store wins.
  - stallM = access (combinational).
  - On access: latch op, funct3, address and data, then go to REQ.
  - Illegal funct3 (load 011/110/111, store 011–111): go to DONE with no request; ReadDataW = 0.
- REQ:
  - dmem_req = 1, with addr/we/wdata/wstrb held stable from the latched copies.
  - stallM = 1.
  - On dmem_gnt: a store goes to DONE; a load goes to WAIT.
- WAIT:
  - stallM = 1.
  - On dmem_rvalid: format dmem_rdata, register it into ReadDataW, go to DONE.
- DONE:
  - stallM = 0 and ReadValidW = 1 (loads only). The pipeline advances at the end of this cycle.
  - M-stage inputs are ignored in DONE; this prevents re-triggering on the same instruction.
  - Next state is IDLE unconditionally.
- Store formatting:
  - SB (000): wdata = {4{rs2[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH (001): wdata = {2{rs2[15:0]}}, wstrb = 0011 << {addr[1],0}.
  - SW (010): wdata = rs2, wstrb = 1111.
- Load formatting:
  - LB (000) and LBU (100): byte lane addr[1:0], sign-/zero-extended.
  - LH (001) and LHU (101): half lane addr[1], sign-/zero-extended.
  - LW (010): full word.
- Latency (stall cycles = cycles before DONE):
  - Store with immediate gnt: 3 cycles total (IDLE, REQ, DONE).
  - Load with immediate gnt and rvalid one cycle later: 4 cycles (IDLE, REQ, WAIT, DONE).
  - Each extra gnt/rvalid wait cycle adds one.
- Other rules:
  - ReadDataW holds its value until the next load completes.
  - dmem_rvalid outside WAIT is ignored.
  - A non-access cycle in IDLE produces no stall.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Halfword with addr[0] = 1, or word with addr[1:0] ≠ 0, issues no request.
  - The unit goes IDLE→DONE with misalignM = 1 for the DONE cycle. ReadValidW = 0, and ReadDataW is unchanged.
- Undefined:
  - misalignM is tied to 0.
  - Misaligned low address bits are ignored: halfword uses addr[1] only, word uses lane 0, and the access proceeds normally.

Decomposition:
- Shared defines/package, alongside the opcode defines:
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW.
  - The 2-bit state encoding (IDLE = 0, REQ = 1, WAIT = 2, DONE = 3).
- Sub-module: lsu_load_formatter, a combinational lane select plus extension of (rdata, funct3, addr[1:0]). It is reusable by a future cache path.

Test Plan:
1. SW: addr 0x104, data 0xDEADBEEF, gnt immediate → one dmem_req cycle with addr 0x104, wstrb 1111, wdata 0xDEADBEEF; stallM high for exactly 2 cycles, then low in DONE.
2. SB: addr 0x203, rs2 0x12345678 → wstrb 1000, wdata 0x78787878, dmem_addr 0x200; SH at 0x202 with rs2 0x0000ABCD → wstrb 1100, wdata 0xABCDABCD.
3. Load, rdata 0x80FF7F01 at addr 0x301: LB → 0x0000007F; LBU at 0x303 → 0x00000080; LB at 0x303 → 0xFFFFFF80; LH at 0x302 → 0xFFFF80FF; LHU at 0x302 → 0x000080FF; each with one ReadValidW pulse.
4. Backpressure: gnt held low 3 cycles, then rvalid 2 cycles after gnt → dmem_req and all request fields stable throughout; stallM stays high until DONE; same-instruction inputs during DONE cause no second request.
5. rst asserted in WAIT, then rvalid the next cycle → IDLE, all outputs 0, no ReadValidW; illegal load funct3 110 → no dmem_req, ReadDataW 0.
6. With MISALIGN_TRAP_EN: LW at 0x102 → no dmem_req, misalignM pulse; without the macro: LW reads 0x100 normally and misalignM stays 0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: funct3 codes, FSM encoding,
// latched command payload and small decode helpers.
package mem_access_unit_pkg;

  localparam int unsigned XLEN = 32;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsuState_e;

  // Command captured when an access leaves IDLE
  typedef struct packed {
    logic            isStore;
    logic [2:0]      funct3;
    logic [XLEN-1:0] data;
  } memCmd_t;

  // funct3 encodings that name a real load or store
  function automatic logic isLegalF3(input logic isStore, input logic [2:0] f3);
    logic legal;
    if (isStore) legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else         legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                         (f3 == F3_LBU) || (f3 == F3_LHU);
    return legal;
  endfunction

  // Halfword needs addr[0]==0, word needs addr[1:0]==0
  function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = lo[0];
      2'b10:   mis = |lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// lsu_load_formatter: combinational lane select and sign/zero extension of a
// returned data word for byte, halfword and word loads.
module lsu_load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addrLo,
  output logic [XLEN-1:0] fmtData_c
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Pick the addressed lane, then extend according to funct3
  always_comb begin
    byteSel   = rdata[7:0];
    halfSel   = addrLo[1] ? rdata[31:16] : rdata[15:0];
    fmtData_c = '0;
    case (addrLo)
      2'd0:    byteSel = rdata[7:0];
      2'd1:    byteSel = rdata[15:8];
      2'd2:    byteSel = rdata[23:16];
      default: byteSel = rdata[31:24];
    endcase
    case (funct3)
      F3_LB:   fmtData_c = {{24{byteSel[7]}}, byteSel};
      F3_LBU:  fmtData_c = {24'd0, byteSel};
      F3_LH:   fmtData_c = {{16{halfSel[15]}}, halfSel};
      F3_LHU:  fmtData_c = {16'd0, halfSel};
      F3_LW:   fmtData_c = rdata;
      default: fmtData_c = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store sequencer. Issues one valid/ready data
// memory request per access, stalls the pipeline until it completes, and
// formats load data for writeback. Define MISALIGN_TRAP_EN to trap misaligned
// halfword/word accesses instead of silently aligning them.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemWriteM,
  input  logic              MemtoRegM,
  input  logic [2:0]        strCtrlM,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [31:0]       WriteDataM,
  output logic              stallM,
  output logic [31:0]       ReadDataW,
  output logic              ReadValidW,
  output logic              misalignM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  if (DATA_W != 32) begin : gDataWCheck
    $error("mem_access_unit: only DATA_W = 32 is supported");
  end

  lsuState_e         stateQ, stateD;
  memCmd_t           cmdQ;
  logic [ADDR_W-1:0] addrQ;
  logic [31:0]       readDataQ, fmtData, storeData;
  logic [3:0]        storeStrb;
  logic              readValidQ, misalignQ;
  logic              access, accLegal, accMisalign;
  logic              captureCmd, loadDone, illegalD, trapD;

  assign access   = MemWriteM | MemtoRegM;
  assign accLegal = isLegalF3(MemWriteM, strCtrlM);
`ifdef MISALIGN_TRAP_EN
  assign accMisalign = isMisaligned(strCtrlM, ALUResultM[1:0]);
`else
  assign accMisalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) stateQ <= IDLE;
    else     stateQ <= stateD;
  end

  // Next-state, stall and capture/complete strobes
  always_comb begin
    stateD     = stateQ;
    stallM     = 1'b0;
    captureCmd = 1'b0;
    loadDone   = 1'b0;
    illegalD   = 1'b0;
    trapD      = 1'b0;
    case (stateQ)
      IDLE: begin
        stallM = access;
        if (access) begin
          captureCmd = 1'b1;
          if (!accLegal) begin
            illegalD = 1'b1;
            stateD   = DONE;
          end else if (accMisalign) begin
            trapD  = 1'b1;
            stateD = DONE;
          end else begin
            stateD = REQ;
          end
        end
      end
      REQ: begin
        stallM = 1'b1;
        if (dmem_gnt) stateD = cmdQ.isStore ? DONE : WAIT;
      end
      WAIT: begin
        stallM = 1'b1;
        if (dmem_rvalid) begin
          loadDone = 1'b1;
          stateD   = DONE;
        end
      end
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Command capture and registered writeback/trap outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cmdQ       <= '0;
      addrQ      <= '0;
      readDataQ  <= '0;
      readValidQ <= 1'b0;
      misalignQ  <= 1'b0;
    end else begin
      if (captureCmd) begin
        cmdQ  <= memCmd_t'{isStore: MemWriteM, funct3: strCtrlM, data: WriteDataM};
        addrQ <= ALUResultM;
      end
      readValidQ <= loadDone | (illegalD & ~MemWriteM);
      misalignQ  <= trapD;
      if (loadDone)                    readDataQ <= fmtData;
      else if (illegalD & ~MemWriteM)  readDataQ <= '0;
    end
  end

  // Store lane replication and byte strobes from the latched command
  always_comb begin
    storeData = '0;
    storeStrb = '0;
    case (cmdQ.funct3)
      F3_SB: begin
        storeData = {4{cmdQ.data[7:0]}};
        storeStrb = 4'b0001 << addrQ[1:0];
      end
      F3_SH: begin
        storeData = {2{cmdQ.data[15:0]}};
        storeStrb = 4'b0011 << {addrQ[1], 1'b0};
      end
      F3_SW: begin
        storeData = cmdQ.data;
        storeStrb = 4'b1111;
      end
      default: begin
        storeData = '0;
        storeStrb = '0;
      end
    endcase
  end

  lsu_load_formatter uFormatter (
    .rdata     (dmem_rdata),
    .funct3    (cmdQ.funct3),
    .addrLo    (addrQ[1:0]),
    .fmtData_c (fmtData)
  );

  assign dmem_req   = (stateQ == REQ);
  assign dmem_we    = dmem_req & cmdQ.isStore;
  assign dmem_addr  = dmem_req ? {addrQ[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_wdata = dmem_we ? storeData : '0;
  assign dmem_wstrb = dmem_we ? storeStrb : '0;
  assign ReadDataW  = readDataQ;
  assign ReadValidW = readValidQ;
  assign misalignM  = misalignQ;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemWriteM = 1'b0, MemtoRegM = 1'b0;
  logic [2:0]  strCtrlM = 3'd0;
  logic [31:0] ALUResultM = 32'd0, WriteDataM = 32'd0;
  logic        stallM, ReadValidW, misalignM;
  logic [31:0] ReadDataW;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] lastRead = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .strCtrlM(strCtrlM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .stallM(stallM), .ReadDataW(ReadDataW), .ReadValidW(ReadValidW),
    .misalignM(misalignM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearM();
    MemWriteM = 1'b0; MemtoRegM = 1'b0; strCtrlM = 3'd0;
    ALUResultM = 32'd0; WriteDataM = 32'd0; dmem_gnt = 1'b0;
  endtask

  // Store with grant in the first REQ cycle
  task automatic doStore(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic bothOps,
                         input logic [31:0] expAddr, input logic [3:0] expStrb,
                         input logic [31:0] expWdata);
    MemWriteM = 1'b1; MemtoRegM = bothOps; strCtrlM = f3;
    ALUResultM = addr; WriteDataM = data; dmem_gnt = 1'b1;
    #1;
    chk({tag, ".idleStall"}, 32'(stallM), 32'd1);
    chk({tag, ".idleReq"}, 32'(dmem_req), 32'd0);
    tick(); #1;
    chk({tag, ".req"}, 32'(dmem_req), 32'd1);
    chk({tag, ".we"}, 32'(dmem_we), 32'd1);
    chk({tag, ".addr"}, dmem_addr, expAddr);
    chk({tag, ".wstrb"}, 32'(dmem_wstrb), 32'(expStrb));
    chk({tag, ".wdata"}, dmem_wdata, expWdata);
    chk({tag, ".reqStall"}, 32'(stallM), 32'd1);
    tick(); #1;
    chk({tag, ".doneStall"}, 32'(stallM), 32'd0);
    chk({tag, ".doneReq"}, 32'(dmem_req), 32'd0);
    chk({tag, ".doneRvalidW"}, 32'(ReadValidW), 32'd0);
    tick(); clearM(); #1;
    chk({tag, ".idleReq2"}, 32'(dmem_req), 32'd0);
  endtask

  // Load with immediate grant and read data one cycle later
  task automatic doLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rdata, input logic [31:0] expAddr,
                        input logic [31:0] expData);
    MemtoRegM = 1'b1; MemWriteM = 1'b0; strCtrlM = f3;
    ALUResultM = addr; WriteDataM = 32'h5555AAAA; dmem_gnt = 1'b1;
    #1;
    chk({tag, ".idleStall"}, 32'(stallM), 32'd1);
    tick(); #1;
    chk({tag, ".req"}, 32'(dmem_req), 32'd1);
    chk({tag, ".we"}, 32'(dmem_we), 32'd0);
    chk({tag, ".addr"}, dmem_addr, expAddr);
    chk({tag, ".wstrb"}, 32'(dmem_wstrb), 32'd0);
    tick(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata; #1;
    chk({tag, ".waitReq"}, 32'(dmem_req), 32'd0);
    chk({tag, ".waitStall"}, 32'(stallM), 32'd1);
    tick(); dmem_rvalid = 1'b0; #1;
    chk({tag, ".rvalidW"}, 32'(ReadValidW), 32'd1);
    chk({tag, ".data"}, ReadDataW, expData);
    chk({tag, ".doneStall"}, 32'(stallM), 32'd0);
    chk({tag, ".misalign"}, 32'(misalignM), 32'd0);
    tick(); clearM(); #1;
    chk({tag, ".pulseEnd"}, 32'(ReadValidW), 32'd0);
    chk({tag, ".hold"}, ReadDataW, expData);
    lastRead = expData;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst.stall", 32'(stallM), 32'd0);
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.rdata", ReadDataW, 32'd0);
    chk("rst.rvalid", 32'(ReadValidW), 32'd0);
    chk("rst.mis", 32'(misalignM), 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);

    // Stores
    doStore("sw", 3'b010, 32'h104, 32'hDEADBEEF, 1'b0, 32'h104, 4'b1111, 32'hDEADBEEF);
    doStore("sb", 3'b000, 32'h203, 32'h12345678, 1'b0, 32'h200, 4'b1000, 32'h78787878);
    doStore("sh", 3'b001, 32'h202, 32'h0000ABCD, 1'b0, 32'h200, 4'b1100, 32'hABCDABCD);
    doStore("storeWins", 3'b010, 32'h108, 32'h0BADCAFE, 1'b1, 32'h108, 4'b1111, 32'h0BADCAFE);

    // Loads from 0x80FF7F01
    doLoad("lb301", 3'b000, 32'h301, 32'h80FF7F01, 32'h300, 32'h0000007F);
    doLoad("lbu303", 3'b100, 32'h303, 32'h80FF7F01, 32'h300, 32'h00000080);
    doLoad("lb303", 3'b000, 32'h303, 32'h80FF7F01, 32'h300, 32'hFFFFFF80);
    doLoad("lh302", 3'b001, 32'h302, 32'h80FF7F01, 32'h300, 32'hFFFF80FF);
    doLoad("lhu302", 3'b101, 32'h302, 32'h80FF7F01, 32'h300, 32'h000080FF);

    // Illegal load funct3: no request, result cleared
    MemtoRegM = 1'b1; strCtrlM = 3'b110; ALUResultM = 32'h600; dmem_gnt = 1'b1; #1;
    chk("illLd.stall", 32'(stallM), 32'd1);
    chk("illLd.idleReq", 32'(dmem_req), 32'd0);
    tick(); #1;
    chk("illLd.doneReq", 32'(dmem_req), 32'd0);
    chk("illLd.data", ReadDataW, 32'd0);
    chk("illLd.doneStall", 32'(stallM), 32'd0);
    tick(); clearM(); #1;
    chk("illLd.idleReq2", 32'(dmem_req), 32'd0);
    lastRead = 32'd0;

    // Illegal store funct3: no request
    MemWriteM = 1'b1; strCtrlM = 3'b011; ALUResultM = 32'h610; dmem_gnt = 1'b1; #1;
    tick(); #1;
    chk("illSt.req", 32'(dmem_req), 32'd0);
    chk("illSt.stall", 32'(stallM), 32'd0);
    tick(); clearM(); #1;

    // Backpressure: grant after 3 low cycles, rvalid 2 cycles after grant
    MemtoRegM = 1'b1; strCtrlM = 3'b010; ALUResultM = 32'h40C; dmem_gnt = 1'b0; #1;
    chk("bp.idleStall", 32'(stallM), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      dmem_rvalid = (i == 1);
      dmem_rdata = 32'hBAD0BAD0;
      #1;
      chk("bp.req", 32'(dmem_req), 32'd1);
      chk("bp.addr", dmem_addr, 32'h40C);
      chk("bp.we", 32'(dmem_we), 32'd0);
      chk("bp.wstrb", 32'(dmem_wstrb), 32'd0);
      chk("bp.stall", 32'(stallM), 32'd1);
    end
    tick(); dmem_rvalid = 1'b0; dmem_gnt = 1'b1; #1;
    chk("bp.req4", 32'(dmem_req), 32'd1);
    chk("bp.addr4", dmem_addr, 32'h40C);
    tick(); dmem_gnt = 1'b0; #1;
    chk("bp.wait1Req", 32'(dmem_req), 32'd0);
    chk("bp.wait1Stall", 32'(stallM), 32'd1);
    tick(); dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D; #1;
    chk("bp.wait2Stall", 32'(stallM), 32'd1);
    chk("bp.wait2Valid", 32'(ReadValidW), 32'd0);
    tick(); dmem_rvalid = 1'b0; #1;
    chk("bp.rvalidW", 32'(ReadValidW), 32'd1);
    chk("bp.data", ReadDataW, 32'hCAFEF00D);
    chk("bp.doneStall", 32'(stallM), 32'd0);
    chk("bp.doneReq", 32'(dmem_req), 32'd0);
    tick(); clearM(); #1;
    chk("bp.noReissue", 32'(dmem_req), 32'd0);
    chk("bp.pulseEnd", 32'(ReadValidW), 32'd0);
    lastRead = 32'hCAFEF00D;

    // Misaligned word load
`ifdef MISALIGN_TRAP_EN
    MemtoRegM = 1'b1; strCtrlM = 3'b010; ALUResultM = 32'h102; dmem_gnt = 1'b1; #1;
    chk("mis.stall", 32'(stallM), 32'd1);
    chk("mis.idleReq", 32'(dmem_req), 32'd0);
    tick(); #1;
    chk("mis.req", 32'(dmem_req), 32'd0);
    chk("mis.pulse", 32'(misalignM), 32'd1);
    chk("mis.rvalidW", 32'(ReadValidW), 32'd0);
    chk("mis.dataHeld", ReadDataW, lastRead);
    tick(); clearM(); #1;
    chk("mis.pulseEnd", 32'(misalignM), 32'd0);
`else
    doLoad("lwMis", 3'b010, 32'h102, 32'h13579BDF, 32'h100, 32'h13579BDF);
`endif

    // Reset while waiting for read data, then a late rvalid
    MemtoRegM = 1'b1; strCtrlM = 3'b010; ALUResultM = 32'h500; dmem_gnt = 1'b1; #1;
    tick(); #1;
    chk("rstW.req", 32'(dmem_req), 32'd1);
    tick(); clearM(); rst = 1'b1; #1;
    chk("rstW.waitStall", 32'(stallM), 32'd1);
    tick(); rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h11112222; #1;
    chk("rstW.stall", 32'(stallM), 32'd0);
    chk("rstW.req", 32'(dmem_req), 32'd0);
    chk("rstW.rvalidW", 32'(ReadValidW), 32'd0);
    chk("rstW.data", ReadDataW, 32'd0);
    chk("rstW.mis", 32'(misalignM), 32'd0);
    chk("rstW.wdata", dmem_wdata, 32'd0);
    chk("rstW.wstrb", 32'(dmem_wstrb), 32'd0);
    chk("rstW.we", 32'(dmem_we), 32'd0);
    tick(); dmem_rvalid = 1'b0; #1;
    chk("rstW.lateRvalid", 32'(ReadValidW), 32'd0);
    chk("rstW.lateData", ReadDataW, 32'd0);
    chk("rstW.lateReq", 32'(dmem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
